// File: rtl/cellram_access_scheduler.sv
// CellRAM access sequencer: arbitrates mic writes against PWM reads and times the RAM strobes.
// Optional: define LOOP_PLAYBACK_EN to wrap playback at the end marker instead of stopping.
module cellram_access_scheduler #(
  parameter int DATA_BITS     = 12,
  parameter int ADDR_BITS     = 23,
  parameter int ACCESS_CYCLES = 8,
  parameter logic [ADDR_BITS-1:0] LAST_ADDR = 23'h7FFFFF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RecordEn,
  input  logic                 PlayEn,
  input  logic                 WriteReq,
  input  logic [DATA_BITS-1:0] WriteData,
  input  logic                 ReadReq,
  output logic [DATA_BITS-1:0] ReadData,
  output logic                 ReadValid,
  output logic [ADDR_BITS-1:0] MemAdr,
  output logic [15:0]          MemDOut,
  input  logic [15:0]          MemDIn,
  output logic                 MemDOE,
  output logic                 RamCEn,
  output logic                 RamOEn,
  output logic                 RamWEn,
  output logic                 RamUBn,
  output logic                 RamLBn,
  output logic                 RamADVn,
  output logic                 RamCRE,
  output logic                 MemoryFull,
  output logic                 StopRead
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t                 state;
  logic                   is_wr;
  logic [7:0]             cnt;
  // One extra bit so the record counter can sit at LAST_ADDR+1 without wrapping.
  logic [ADDR_BITS:0]     wr_adr, rd_adr, end_adr;
  logic [DATA_BITS-1:0]   wdata;
  logic                   wpend, rpend, rec_q, play_q;
  logic                   play_mode, wr_ok, rd_ok;

  assign play_mode = PlayEn & ~RecordEn;
  assign wr_ok     = RecordEn & ~MemoryFull;
  assign rd_ok     = play_mode & ~StopRead & (end_adr != '0);

  assign RamUBn  = 1'b0;
  assign RamLBn  = 1'b0;
  assign RamADVn = 1'b0;
  assign RamCRE  = 1'b0;

  generate
    if (DATA_BITS < 16) begin : g_unused
      logic unused_din;
      assign unused_din = ^MemDIn[15:DATA_BITS];
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      cnt        <= '0;
      wr_adr     <= '0;
      rd_adr     <= '0;
      end_adr    <= '0;
      wdata      <= '0;
      wpend      <= 1'b0;
      rpend      <= 1'b0;
      rec_q      <= 1'b0;
      play_q     <= 1'b0;
      MemAdr     <= '0;
      MemDOut    <= '0;
      MemDOE     <= 1'b0;
      RamCEn     <= 1'b1;
      RamOEn     <= 1'b1;
      RamWEn     <= 1'b1;
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      MemoryFull <= 1'b0;
      StopRead   <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      rec_q     <= RecordEn;
      play_q    <= PlayEn;

      case (state)
        IDLE: begin
          if (!RecordEn)  wpend <= 1'b0;
          if (!play_mode) rpend <= 1'b0;
          if (wpend && RecordEn) begin
            state   <= SETUP;
            is_wr   <= 1'b1;
            wpend   <= 1'b0;
            MemAdr  <= wr_adr[ADDR_BITS-1:0];
            MemDOut <= 16'(wdata);
            MemDOE  <= 1'b1;
          end else if (rpend && play_mode && !StopRead) begin
            state  <= SETUP;
            is_wr  <= 1'b0;
            rpend  <= 1'b0;
            MemAdr <= rd_adr[ADDR_BITS-1:0];
          end
        end
        SETUP: begin
          state  <= ACCESS;
          cnt    <= 8'(ACCESS_CYCLES - 1);
          RamCEn <= 1'b0;
          if (is_wr) RamWEn <= 1'b0;
          else       RamOEn <= 1'b0;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= RECOVER;
            RamCEn <= 1'b1;
            RamOEn <= 1'b1;
            RamWEn <= 1'b1;
            MemDOE <= 1'b0;
            if (!is_wr) begin
              ReadData  <= MemDIn[DATA_BITS-1:0];
              ReadValid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          state <= IDLE;
          if (is_wr) begin
            wr_adr  <= wr_adr + 1'b1;
            end_adr <= wr_adr + 1'b1;
            if (wr_adr[ADDR_BITS-1:0] == LAST_ADDR) MemoryFull <= 1'b1;
          end else if (rd_adr + 1'b1 == end_adr) begin
`ifdef LOOP_PLAYBACK_EN
            rd_adr   <= '0;
`else
            rd_adr   <= rd_adr + 1'b1;
            StopRead <= 1'b1;
`endif
          end else begin
            rd_adr <= rd_adr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (RecordEn && !rec_q) begin
        wr_adr     <= '0;
        end_adr    <= '0;
        MemoryFull <= 1'b0;
      end
      if (PlayEn && !play_q) begin
        rd_adr   <= '0;
        StopRead <= 1'b0;
      end
`ifndef LOOP_PLAYBACK_EN
      else if (play_mode && end_adr == '0) begin
        StopRead <= 1'b1;
      end
`endif

      // Placed after the FSM so a request landing on the consume cycle is kept.
      if (WriteReq && wr_ok) begin
        wpend <= 1'b1;
        wdata <= WriteData;
      end
      if (ReadReq && rd_ok) rpend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cellram_access_scheduler.sv
// Bench for cellram_access_scheduler: table-driven writes/reads, RAM model, access scoreboard.
module tb_cellram_access_scheduler;

  logic        Clock = 1'b0, Reset = 1'b1;
  logic        RecordEn = 1'b0, PlayEn = 1'b0, WriteReq = 1'b0, ReadReq = 1'b0;
  logic [11:0] WriteData = '0;
  logic [15:0] MemDIn;

  logic [11:0] ReadData;
  logic        ReadValid, MemDOE, RamCEn, RamOEn, RamWEn, RamUBn, RamLBn, RamADVn, RamCRE;
  logic        MemoryFull, StopRead;
  logic [22:0] MemAdr;
  logic [15:0] MemDOut;

  logic [11:0] s_ReadData;
  logic        s_ReadValid, s_MemDOE, s_RamCEn, s_RamOEn, s_RamWEn, s_RamUBn, s_RamLBn;
  logic        s_RamADVn, s_RamCRE, s_MemoryFull, s_StopRead;
  logic [22:0] s_MemAdr;
  logic [15:0] s_MemDOut;

  cellram_access_scheduler u_dut (
    .Clock(Clock), .Reset(Reset), .RecordEn(RecordEn), .PlayEn(PlayEn),
    .WriteReq(WriteReq), .WriteData(WriteData), .ReadReq(ReadReq),
    .ReadData(ReadData), .ReadValid(ReadValid), .MemAdr(MemAdr), .MemDOut(MemDOut),
    .MemDIn(MemDIn), .MemDOE(MemDOE), .RamCEn(RamCEn), .RamOEn(RamOEn), .RamWEn(RamWEn),
    .RamUBn(RamUBn), .RamLBn(RamLBn), .RamADVn(RamADVn), .RamCRE(RamCRE),
    .MemoryFull(MemoryFull), .StopRead(StopRead));

  cellram_access_scheduler #(.LAST_ADDR(23'd3)) u_small (
    .Clock(Clock), .Reset(Reset), .RecordEn(RecordEn), .PlayEn(PlayEn),
    .WriteReq(WriteReq), .WriteData(WriteData), .ReadReq(ReadReq),
    .ReadData(s_ReadData), .ReadValid(s_ReadValid), .MemAdr(s_MemAdr), .MemDOut(s_MemDOut),
    .MemDIn(MemDIn), .MemDOE(s_MemDOE), .RamCEn(s_RamCEn), .RamOEn(s_RamOEn),
    .RamWEn(s_RamWEn), .RamUBn(s_RamUBn), .RamLBn(s_RamLBn), .RamADVn(s_RamADVn),
    .RamCRE(s_RamCRE), .MemoryFull(s_MemoryFull), .StopRead(s_StopRead));

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  // RAM model driven by the main instance.
  logic [15:0] ram [16] = '{default: 16'h0};
  always @(posedge Clock) if (!RamCEn && !RamWEn) ram[MemAdr[3:0]] <= MemDOut;
  assign MemDIn = ram[MemAdr[3:0]];

  typedef struct { logic is_wr; logic [11:0] data; logic [22:0] adr; } acc_t;
  typedef struct { logic [11:0] wdata; logic [22:0] adr; } vec_t;

  acc_t        exp_acc[$];
  logic [11:0] exp_rd[$];
  int          rq_cyc[$];
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_adr"}, MemAdr, 0);
    chk({tag, "_dout"}, MemDOut, 0);
    chk({tag, "_doe"}, MemDOE, 0);
    chk({tag, "_strobes"}, {RamCEn, RamOEn, RamWEn}, 3'b111);
    chk({tag, "_fixed"}, {RamUBn, RamLBn, RamADVn, RamCRE}, 4'b0000);
    chk({tag, "_rdata"}, ReadData, 0);
    chk({tag, "_rvalid"}, ReadValid, 0);
    chk({tag, "_flags"}, {MemoryFull, StopRead}, 2'b00);
  endtask

  task automatic do_write(input logic [11:0] d, input logic [22:0] adr, input bit expect_acc);
    acc_t e;
    e.is_wr = 1'b1; e.data = d; e.adr = adr;
    if (expect_acc) exp_acc.push_back(e);
    WriteData = d; WriteReq = 1'b1;
    tick();
    WriteReq = 1'b0;
    tick(13);
  endtask

  task automatic do_read(input logic [11:0] d, input logic [22:0] adr, input bit expect_acc);
    acc_t e;
    e.is_wr = 1'b0; e.data = d; e.adr = adr;
    if (expect_acc) begin
      exp_acc.push_back(e);
      exp_rd.push_back(d);
      rq_cyc.push_back(cyc);
    end
    ReadReq = 1'b1;
    tick();
    ReadReq = 1'b0;
    tick(13);
  endtask

  // Access scoreboard: every strobe burst must match the next expected access.
  logic prev_cen = 1'b1, aborted = 1'b0;
  int   lowcnt = 0;
  always @(negedge Clock) begin : mon
    acc_t e;
    if (Reset) begin
      prev_cen = 1'b1; lowcnt = 0; aborted = 1'b1;
    end else begin
      if (!RamCEn && prev_cen) begin
        aborted = 1'b0; lowcnt = 0;
        if (exp_acc.size() == 0) chk("unexpected_access", 1, 0);
        else begin
          e = exp_acc.pop_front();
          chk("acc_is_write", !RamWEn, e.is_wr);
          chk("acc_adr", MemAdr, e.adr);
          if (e.is_wr) begin
            chk("acc_dout", MemDOut, {4'h0, e.data});
            chk("acc_doe", MemDOE, 1);
          end
        end
      end
      if (!RamCEn && (RamWEn ^ RamOEn)) lowcnt++;
      if (RamCEn && !prev_cen && !aborted) begin
        chk("strobe_width", lowcnt, 8);
        chk("recover_doe", MemDOE, 0);
      end
      prev_cen = RamCEn;
      if (ReadValid) begin
        if (exp_rd.size() == 0) chk("unexpected_readvalid", 1, 0);
        else begin
          chk("read_data", ReadData, exp_rd.pop_front());
          chk("read_latency", cyc - rq_cyc.pop_front(), 11);
        end
      end
    end
  end

  logic s_prev_wen = 1'b1;
  int   s_wcnt = 0;
  logic [22:0] s_last_adr = '0;
  always @(negedge Clock) begin
    if (!s_RamWEn && s_prev_wen) begin
      s_wcnt++;
      s_last_adr = s_MemAdr;
    end
    s_prev_wen = s_RamWEn;
  end

  initial begin
    vec_t vecs[3];
    vecs[0] = '{12'hA01, 23'd0};
    vecs[1] = '{12'hA02, 23'd1};
    vecs[2] = '{12'hA03, 23'd2};

    tick(3);
    check_reset_vals("reset");
    Reset = 1'b0;
    tick(2);

    // Play with nothing recorded: end marker is 0.
    PlayEn = 1'b1;
    tick(2);
`ifdef LOOP_PLAYBACK_EN
    chk("empty_play_stop", StopRead, 0);
`else
    chk("empty_play_stop", StopRead, 1);
`endif
    do_read(12'h0, 23'd0, 1'b0);
    PlayEn = 1'b0;
    tick(2);

    // Reset in the middle of a write access.
    RecordEn = 1'b1;
    tick(2);
    begin
      acc_t e;
      e.is_wr = 1'b1; e.data = 12'h123; e.adr = 23'd0;
      exp_acc.push_back(e);
    end
    WriteData = 12'h123; WriteReq = 1'b1;
    tick();
    WriteReq = 1'b0;
    for (int i = 0; i < 20 && RamWEn; i++) tick();
    chk("mid_wen_low", RamWEn, 0);
    tick(3);
    #2 Reset = 1'b1;
    #1;
    chk("async_strobes", {RamCEn, RamWEn}, 2'b11);
    chk("async_doe", MemDOE, 0);
    tick(2);
    Reset = 1'b0; RecordEn = 1'b0;
    tick(2);
    check_reset_vals("post_reset");

    // Record three samples from the table.
    RecordEn = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) do_write(vecs[i].wdata, vecs[i].adr, 1'b1);
    chk("rec_full", MemoryFull, 0);

    // Play them back.
    RecordEn = 1'b0; PlayEn = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) chk("stop_before_last", StopRead, 0);
      do_read(vecs[i].wdata, vecs[i].adr, 1'b1);
    end
`ifdef LOOP_PLAYBACK_EN
    chk("loop_no_stop", StopRead, 0);
    do_read(vecs[0].wdata, vecs[0].adr, 1'b1);
`else
    chk("stop_after_last", StopRead, 1);
    do_read(12'h0, 23'd0, 1'b0);
    chk("stop_held", StopRead, 1);
`endif

    // Write and read on the same cycle with both modes high: write only.
    RecordEn = 1'b1;
    tick(2);
    begin
      acc_t e;
      e.is_wr = 1'b1; e.data = 12'h5A5; e.adr = 23'd0;
      exp_acc.push_back(e);
    end
    WriteData = 12'h5A5; WriteReq = 1'b1; ReadReq = 1'b1;
    tick();
    WriteReq = 1'b0; ReadReq = 1'b0;
    tick(26);
    chk("tie_one_access", exp_acc.size(), 0);

    // Memory-full boundary on the LAST_ADDR=3 instance.
    RecordEn = 1'b0;
    tick(2);
    RecordEn = 1'b1;
    tick(2);
    s_wcnt = 0;
    for (int i = 0; i < 5; i++) begin
      do_write(12'hB00 + 12'(i), 23'(i), 1'b1);
      if (i == 2) chk("small_full_early", s_MemoryFull, 0);
      if (i == 3) chk("small_full_at_last", s_MemoryFull, 1);
    end
    chk("small_write_count", s_wcnt, 4);
    chk("small_last_adr", s_last_adr, 3);
    chk("small_full_held", s_MemoryFull, 1);
    chk("big_not_full", MemoryFull, 0);

`ifdef LOOP_PLAYBACK_EN
    // Two-sample recording replayed five times around the loop.
    RecordEn = 1'b0; PlayEn = 1'b0;
    tick(2);
    RecordEn = 1'b1;
    tick(2);
    do_write(12'hC01, 23'd0, 1'b1);
    do_write(12'hC02, 23'd1, 1'b1);
    RecordEn = 1'b0; PlayEn = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++)
      do_read((i % 2 == 0) ? 12'hC01 : 12'hC02, 23'(i % 2), 1'b1);
    chk("loop_stop_low", StopRead, 0);
`endif

    tick(4);
    chk("acc_queue_drained", exp_acc.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
